// File: rtl/txt_status_pkg.sv
// Shared constants and types for the status-text overlay chain.
// Window size is derived from the character grid.
package txt_status_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int TXT_COLS    = 16;
  localparam int TXT_ROWS    = 16;
  localparam int FONT_ADDR_W = 11;
  localparam int RGB_W       = 12;

  localparam int WIN_W = CHAR_W * TXT_COLS;
  localparam int WIN_H = CHAR_H * TXT_ROWS;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

endpackage

// File: rtl/txt_status_ctl_if.sv
// Pixel stream, character-map and font-ROM signals of the overlay stage.
// The slave side is the overlay block; the master side is its environment.
interface txt_status_ctl_if;
  import txt_status_pkg::*;

  logic [10:0]            hcount_in;
  logic [10:0]            vcount_in;
  logic                   hsync_in;
  logic                   vsync_in;
  logic                   hblnk_in;
  logic                   vblnk_in;
  logic [RGB_W-1:0]       rgb_in;
  logic                   blink_en;

  logic [7:0]             char_xy;
  logic [3:0]             char_line;
  logic [6:0]             char_code;
  logic [FONT_ADDR_W-1:0] font_addr;
  logic [7:0]             font_pixels;

  logic [10:0]            hcount_out;
  logic [10:0]            vcount_out;
  logic                   hsync_out;
  logic                   vsync_out;
  logic                   hblnk_out;
  logic                   vblnk_out;
  logic [RGB_W-1:0]       rgb_out;

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, blink_en, char_code, font_pixels,
    output char_xy, char_line, font_addr,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out
  );

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, blink_en, char_code, font_pixels,
    input  char_xy, char_line, font_addr,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out
  );

endinterface

// File: rtl/vga_delay.sv
// Parameterised register line: DEPTH stages of WIDTH bits, synchronous
// active-high reset clears every stage to zero.
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_rst) r_stage[gi] <= '0;
          else       r_stage[gi] <= i_data;
        end
      end else begin : g_next
        always_ff @(posedge i_clk) begin
          if (i_rst) r_stage[gi] <= '0;
          else       r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/txt_status_ctl.sv
// Status-text overlay: addresses the character map and font ROM for each pixel
// and paints the glyph over the incoming RGB stream with 3 pclk of latency.
module txt_status_ctl
  import txt_status_pkg::*;
#(
  parameter logic [10:0]      XPOS       = 11'd16,
  parameter logic [10:0]      YPOS       = 11'd16,
  parameter logic [RGB_W-1:0] FG_RGB     = 12'hFFF,
  parameter int               BLINK_HALF = 30
) (
  input  logic              pclk,
  input  logic              rst,
  txt_status_ctl_if.slave   bus
);

  localparam logic [11:0] X_END = {1'b0, XPOS} + 12'(WIN_W);
  localparam logic [11:0] Y_END = {1'b0, YPOS} + 12'(WIN_H);
  localparam int          FC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_HALF - 1);

  logic [6:0]  w_rel_x;
  logic [7:0]  w_rel_y;
  logic        w_in_win;

  assign w_rel_x  = 7'(bus.hcount_in - XPOS);
  assign w_rel_y  = 8'(bus.vcount_in - YPOS);
  assign w_in_win = ({1'b0, bus.hcount_in} >= {1'b0, XPOS}) &&
                    ({1'b0, bus.hcount_in} <  X_END) &&
                    ({1'b0, bus.vcount_in} >= {1'b0, YPOS}) &&
                    ({1'b0, bus.vcount_in} <  Y_END);

  // Timing and counts ride a 3-deep line straight to the outputs.
  vga_timing_t w_tim_in;
  vga_timing_t w_tim_out;

  assign w_tim_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                      hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                      hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in};

  vga_delay #(.WIDTH($bits(vga_timing_t)), .DEPTH(3)) u_tim_dly (
    .i_clk  (pclk),
    .i_rst  (rst),
    .i_data (w_tim_in),
    .o_data (w_tim_out)
  );

  // Blanking and background colour are needed one stage early to form rgb_out.
  logic [RGB_W+1:0] w_pix_dly;
  logic             w_hblnk_s2;
  logic             w_vblnk_s2;
  logic [RGB_W-1:0] w_rgb_s2;

  vga_delay #(.WIDTH(RGB_W + 2), .DEPTH(2)) u_pix_dly (
    .i_clk  (pclk),
    .i_rst  (rst),
    .i_data ({bus.hblnk_in, bus.vblnk_in, bus.rgb_in}),
    .o_data (w_pix_dly)
  );

  assign {w_hblnk_s2, w_vblnk_s2, w_rgb_s2} = w_pix_dly;

  logic [7:0]       r_char_xy;
  logic [3:0]       r_char_line;
  logic [2:0]       r_px_col_q1;
  logic [2:0]       r_px_col_q2;
  logic             r_in_win_q1;
  logic             r_in_win_q2;
  logic [RGB_W-1:0] r_rgb_out;
  logic             r_vsync_prev;
  logic [FC_W-1:0]  r_frame_cnt;
  logic             r_blink_ph;

  logic             w_pix;
  logic             w_visible;
  logic             w_vs_edge;

  assign w_pix     = bus.font_pixels[3'd7 - r_px_col_q2];
  assign w_visible = ~bus.blink_en | r_blink_ph;
  assign w_vs_edge = bus.vsync_in & ~r_vsync_prev;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_char_xy   <= 8'h00;
      r_char_line <= 4'h0;
      r_px_col_q1 <= 3'd0;
      r_px_col_q2 <= 3'd0;
      r_in_win_q1 <= 1'b0;
      r_in_win_q2 <= 1'b0;
      r_rgb_out   <= '0;
    end else begin
      r_char_xy   <= w_in_win ? {w_rel_y[7:4], w_rel_x[6:3]} : 8'h00;
      r_char_line <= w_in_win ? w_rel_y[3:0] : 4'h0;
      r_px_col_q1 <= w_rel_x[2:0];
      r_in_win_q1 <= w_in_win;
      r_px_col_q2 <= r_px_col_q1;
      r_in_win_q2 <= r_in_win_q1;
      if (w_hblnk_s2 || w_vblnk_s2)
        r_rgb_out <= '0;
      else if (r_in_win_q2 && w_pix && w_visible)
        r_rgb_out <= FG_RGB;
      else
        r_rgb_out <= w_rgb_s2;
    end
  end

  // Blink phase flips every BLINK_HALF vsync rising edges, whatever blink_en says.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
      r_frame_cnt  <= '0;
      r_blink_ph   <= 1'b1;
    end else begin
      r_vsync_prev <= bus.vsync_in;
      if (w_vs_edge) begin
        if (r_frame_cnt == FC_LAST) begin
          r_frame_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.char_xy    = r_char_xy;
  assign bus.char_line  = r_char_line;
  assign bus.font_addr  = {bus.char_code, bus.char_line};
  assign bus.hcount_out = w_tim_out.hcount;
  assign bus.vcount_out = w_tim_out.vcount;
  assign bus.hsync_out  = w_tim_out.hsync;
  assign bus.vsync_out  = w_tim_out.vsync;
  assign bus.hblnk_out  = w_tim_out.hblnk;
  assign bus.vblnk_out  = w_tim_out.vblnk;
  assign bus.rgb_out    = r_rgb_out;

endmodule
